// File: rtl/parity_tx.sv
// parity_tx: serial transmitter for one nibble, framed as
// start bit, four data bits (a first), a parity bit and a stop bit.
// Every bit is held on tx for CLKS_PER_BIT clock cycles.
module parity_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          ODD_PARITY   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic valid,
   output logic ready,
   output logic tx,
   output logic p,
   output logic done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

   state_t     state_q, state_d;
   logic [7:0] bitCnt_q, bitCnt_d;
   logic [1:0] bitIdx_q, bitIdx_d;
   logic [3:0] shift_q, shift_d;
   logic       p_q, p_d;
   logic       tx_q, tx_d;
   logic       done_q, done_d;
   logic       bitEnd;

   // A bit slot ends on the last cycle of its CLKS_PER_BIT-cycle window.
   assign bitEnd = (bitCnt_q == LAST_CNT);

   // Sequencing and datapath next-state; tx is derived from the next state so it changes in step with the state register.
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      p_d      = p_q;
      done_d   = 1'b0;
      tx_d     = 1'b1;

      if (state_q != IDLE) begin
         bitCnt_d = bitEnd ? 8'd0 : bitCnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            bitCnt_d = 8'd0;
            bitIdx_d = 2'd0;
            if (valid) begin
               state_d = START;
               shift_d = {a, b, c, d};
               p_d     = a ^ b ^ c ^ d ^ ODD_PARITY;
            end
         end
         START: begin
            if (bitEnd) begin
               state_d  = DATA;
               bitIdx_d = 2'd0;
            end
         end
         DATA: begin
            if (bitEnd) begin
               shift_d = {shift_q[2:0], 1'b0};
               if (bitIdx_q == 2'd3) begin
                  state_d  = PARITY;
                  bitIdx_d = 2'd0;
               end else begin
                  bitIdx_d = bitIdx_q + 2'd1;
               end
            end
         end
         PARITY: begin
            if (bitEnd) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bitEnd) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            bitCnt_d = 8'd0;
            bitIdx_d = 2'd0;
         end
      endcase

      case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[3];
         PARITY:  tx_d = p_d;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame and parks the line high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         bitCnt_q <= 8'd0;
         bitIdx_q <= 2'd0;
         shift_q  <= 4'd0;
         p_q      <= 1'b0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         p_q      <= p_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign tx    = tx_q;
   assign p     = p_q;
   assign done  = done_q;

endmodule

// File: doc/parity_tx.md
PARITY_TX -- requirements
Module: parity_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles each serial bit is held on tx (legal range 1..255).
REQ-002 Parameter: ODD_PARITY, default 0; 0 = even parity (a^b^c^d^p = 0), 1 = odd parity (a^b^c^d^p = 1).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a, b, c, d  input  1 each  data bits of the nibble to send; a is transmitted first.
REQ-006 valid  input  1  request to send the nibble on a..d.
REQ-007 ready  output  1  high when a new nibble can be accepted.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 p  output  1  registered parity bit of the nibble currently latched.
REQ-010 done  output  1  one-cycle pulse when the stop bit completes.

Function
REQ-011 Accept a nibble only on a rising edge with valid=1 and ready=1, latching a,b,c,d into an internal 4-bit shift register.
REQ-012 Compute p at accept as a^b^c^d when ODD_PARITY=0, and ~(a^b^c^d) when ODD_PARITY=1; p holds until the next accept.
REQ-013 Use FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a bit counter.
REQ-014 IDLE: tx=1, ready=1; on accept -> START.
REQ-015 START: tx=0; on bit-counter expiry -> DATA with bit index 0.
REQ-016 DATA: tx = latched data bit (a, b, c, d in order); after the 4th bit -> PARITY.
REQ-017 PARITY: tx=p; on expiry -> STOP.
REQ-018 STOP: tx=1; on expiry assert done for exactly one cycle and -> IDLE.
REQ-019 ready=0 in every state except IDLE; valid while ready=0 is ignored, with no queuing.
REQ-020 Changes on a..d after accept do not affect the frame in progress.
REQ-021 The frame is 7 bits, and total time from accept to done is 7*CLKS_PER_BIT cycles.
REQ-022 tx is driven from a register, with no combinational path from inputs to tx.
REQ-023 With valid held high continuously, the next accept occurs in the cycle after done, so the frames are back-to-back with no extra idle bit.
REQ-024 The bit counter and bit index wrap to 0 on every state transition and never exceed CLKS_PER_BIT-1 and 3 respectively.

Reset
REQ-025 While rst=1, regardless of clk: state=IDLE, tx=1, ready=1, p=0, done=0, shift register=0, counters=0.
REQ-026 Reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously), and no done pulse is issued.
REQ-027 After rst deasserts, the first accept is possible on the first rising edge with valid=1.

Verification
REQ-028 Reset: assert rst mid-cycle -> tx=1, ready=1, done=0, p=0 without waiting for a clock edge.
REQ-029 Even frame: defaults, {a,b,c,d}=1,0,1,1, valid pulse -> tx sequence 0,1,0,1,1,1,1 with each bit 4 cycles, p=1, done pulse 28 cycles after accept.
REQ-030 Odd parity: ODD_PARITY=1, nibble 0000 -> p=1, parity slot of tx=1; a downstream parity checker of the matching sense reports no error.
REQ-031 Exhaustive: all 16 nibbles sent back-to-back with valid held high -> each frame decodes to the sent nibble, a^b^c^d^p=0, and there are no idle gaps between frames.
REQ-032 Busy and abort: valid pulsed during DATA is ignored and ready=0 throughout the frame; then rst asserted during PARITY -> tx=1, no done pulse, and the next frame is correct.
REQ-033 CLKS_PER_BIT=1 -> 7-cycle frame, done on cycle 7 after accept, and correct bit order.
